vga_timing_gen: RTL and testbench
=================================

Name: vga_timing_gen

Overview:
- Parametrised raster timing generator. Successor to the fixed 640x480 VGA sync FSM.
- Derives the pixel rate from the system clock with an internal clock-enable divider; there is no generated clock.
- Outputs registered sync, data-enable, pixel coordinates and line/frame strobes.
- Feeds the framebuffer read path and the vector-to-raster display logic.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BP, 33, vertical back porch (lines)
- HS_POL, 0, asserted level of hsync (0 = active-low)
- VS_POL, 0, asserted level of vsync
- CLK_DIV, 2, clk cycles per pixel (>=1)
- COL_W, 10, col output width
- ROW_W, 9, row output width

Ports:
- clk  input  1  system clock; only clock
- rst  input  1  synchronous, active-high reset
- en  input  1  run enable; low freezes the raster
- hsync  output  1  horizontal sync, polarity HS_POL
- vsync  output  1  vertical sync, polarity VS_POL
- de  output  1  active-video data enable
- vblank  output  1  high while the line is outside V_ACTIVE
- col  output  COL_W  active pixel column; 0 outside active
- row  output  ROW_W  active line; 0 outside active
- pix_ce  output  1  one-clk pixel strobe qualifying all outputs
- line_start  output  1  one-clk pulse on the pixel at h position 0
- frame_start  output  1  one-clk pulse on the pixel at position (0,0)

Behaviour:
- Reset is synchronous and active-high, one clock (clk). rst dominates en.
- Timing constants:
  - H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP
  - V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP
- Line layout, in order: active, front porch, sync, back porch. Frame layout uses the same order.
- Internal counters:
  - div_cnt runs 0..CLK_DIV-1.
  - h_cnt runs 0..H_TOTAL-1; v_cnt runs 0..V_TOTAL-1.
  - Counter widths are $clog2 of the respective totals.
- tick = en && (div_cnt == CLK_DIV-1). With CLK_DIV=1, tick = en.
- Counter update rules:
  - div_cnt increments while en and wraps to 0 on tick.
  - On tick: h_cnt increments. At H_TOTAL-1 it wraps to 0 and v_cnt increments; v_cnt wraps to 0 at V_TOTAL-1.
  - en low: all counters hold and tick = 0.
- Every output is a register loaded every clk from a decode of the current (h_cnt, v_cnt, tick). Latency is one clk, and all outputs are mutually aligned.
- Output decodes:
  - pix_ce <= tick
  - de <= h_cnt<H_ACTIVE && v_cnt<V_ACTIVE
  - vblank <= v_cnt>=V_ACTIVE
  - col <= de-term ? h_cnt : 0
  - row <= de-term ? v_cnt : 0 (same de-term as de)
  - hsync <= HS_POL when H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC, else ~HS_POL
  - vsync <= VS_POL when V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC, else ~VS_POL. Changes only with v_cnt.
  - line_start <= tick && h_cnt==0
  - frame_start <= tick && h_cnt==0 && v_cnt==0
- Reset values:
  - All counters are 0.
  - de, vblank, col, row, pix_ce, line_start and frame_start are 0.
  - hsync = ~HS_POL; vsync = ~VS_POL.
- First frame_start pulse is on the CLK_DIV-th rising edge after rst deasserts (en held high).
- Outputs do not hold while en is low: the decode registers keep loading every clk from the frozen counters.
  - Level outputs (de, vblank, col, row, hsync, vsync) therefore stay constant.
  - pix_ce, line_start and frame_start are 0 while en is low.
- rst asserted mid-frame returns everything to the reset state on the next edge, with no partial-line completion.
- Elaboration errors:
  - CLK_DIV < 1
  - any sync width or active size of 0
  - H_ACTIVE > 2^COL_W
  - V_ACTIVE > 2^ROW_W

Test Plan:
- Small raster: H=8/2/3/3 (total 16), V=4/1/2/1 (total 8), CLK_DIV=1, en=1.
  - Expect frame_start period 128 clks and line_start period 16.
  - Expect exactly 32 de clks per frame, with col 0..7 and row 0..3 in order.
- Same raster, sync decode:
  - hsync low for exactly 3 clks per line, starting 10 clks after line_start.
  - vsync low for exactly 2 lines (32 clks), starting at line 5.
  - vblank high for lines 4..7.
- Default parameters, CLK_DIV=2:
  - Expect pix_ce on alternate clks.
  - Expect frame_start period 840000 clks and the first frame_start on the 2nd edge after rst release.
  - Expect hsync low for 96 pixels (192 clks).
- Polarity: HS_POL=1, VS_POL=1.
  - Reset levels are hsync=0, vsync=0.
  - Pulses are high with unchanged widths and positions.
- Enable gating, small raster: drop en for 5 clks mid-active line.
  - pix_ce, line_start and frame_start are 0 throughout; col, de and hsync stay constant.
  - On resume, col continues from the frozen value +1 and the frame period stretches by exactly 5 clks.
- Reset mid-frame, at h=9, v=2:
  - Next edge: all outputs at reset values.
  - After release: frame_start on the CLK_DIV-th edge, with row=0 and col=0.

Source files
------------

// File: rtl/vga_timing_if.sv
// vga_timing_if: raster timing bundle between the generator and its consumers.
// en flows into the generator; sync, enable, coordinates and strobes flow out.
interface vga_timing_if #(
  parameter int COL_W = 10,
  parameter int ROW_W = 9
);
  logic             en;
  logic             hsync;
  logic             vsync;
  logic             de;
  logic             vblank;
  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic             pix_ce;
  logic             line_start;
  logic             frame_start;

  modport master (
    input  en,
    output hsync, vsync, de, vblank,
    output col, row,
    output pix_ce, line_start, frame_start
  );

  modport slave (
    output en,
    input  hsync, vsync, de, vblank,
    input  col, row,
    input  pix_ce, line_start, frame_start
  );
endinterface

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised raster timing with a clock-enable pixel divider.
// Ports: i_clk, i_rst (sync, active-high), vga (master: en in; syncs/de/coords/strobes out).
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int HS_POL   = 0,
  parameter int VS_POL   = 0,
  parameter int CLK_DIV  = 2,
  parameter int COL_W    = 10,
  parameter int ROW_W    = 9
) (
  input  logic         i_clk,
  input  logic         i_rst,
  vga_timing_if.master vga
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int H_SS = H_ACTIVE + H_FP;
  localparam int H_SE = H_SS + H_SYNC;
  localparam int V_SS = V_ACTIVE + V_FP;
  localparam int V_SE = V_SS + V_SYNC;
  localparam logic HS_ON = (HS_POL != 0);
  localparam logic VS_ON = (VS_POL != 0);

  if (CLK_DIV < 1) begin : g_bad_div
    $error("vga_timing_gen: CLK_DIV must be >= 1");
  end
  if (H_ACTIVE < 1 || V_ACTIVE < 1) begin : g_bad_act
    $error("vga_timing_gen: active size must be nonzero");
  end
  if (H_SYNC < 1 || V_SYNC < 1) begin : g_bad_sync
    $error("vga_timing_gen: sync width must be nonzero");
  end
  if (longint'(H_ACTIVE) > (64'd1 << COL_W)) begin : g_bad_colw
    $error("vga_timing_gen: COL_W too narrow for H_ACTIVE");
  end
  if (longint'(V_ACTIVE) > (64'd1 << ROW_W)) begin : g_bad_roww
    $error("vga_timing_gen: ROW_W too narrow for V_ACTIVE");
  end

  logic [DW-1:0] r_div;
  logic [HW-1:0] r_h;
  logic [VW-1:0] r_v;

  logic [31:0] w_h;
  logic [31:0] w_v;
  logic        w_tick;
  logic        w_h_last;
  logic        w_v_last;
  logic        w_act;
  logic        w_hs_on;
  logic        w_vs_on;

  // Compare in 32 bits so sync-end bounds equal to the total never wrap.
  assign w_h      = 32'(r_h);
  assign w_v      = 32'(r_v);
  assign w_tick   = vga.en && (r_div == DW'(CLK_DIV - 1));
  assign w_h_last = (w_h == 32'(H_TOTAL - 1));
  assign w_v_last = (w_v == 32'(V_TOTAL - 1));
  assign w_act    = (w_h < H_ACTIVE) && (w_v < V_ACTIVE);
  assign w_hs_on  = (w_h >= H_SS) && (w_h < H_SE);
  assign w_vs_on  = (w_v >= V_SS) && (w_v < V_SE);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_div <= '0;
      r_h   <= '0;
      r_v   <= '0;
    end else begin
      if (w_tick) begin
        r_div <= '0;
      end else if (vga.en) begin
        r_div <= r_div + 1'b1;
      end
      if (w_tick) begin
        if (w_h_last) begin
          r_h <= '0;
          r_v <= w_v_last ? '0 : r_v + 1'b1;
        end else begin
          r_h <= r_h + 1'b1;
        end
      end
    end
  end

  logic             r_hs;
  logic             r_vs;
  logic             r_de;
  logic             r_vb;
  logic [COL_W-1:0] r_col;
  logic [ROW_W-1:0] r_row;
  logic             r_ce;
  logic             r_ls;
  logic             r_fs;

  // Decode reloads every clk, so level outputs track frozen counters while en is low.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_hs  <= ~HS_ON;
      r_vs  <= ~VS_ON;
      r_de  <= 1'b0;
      r_vb  <= 1'b0;
      r_col <= '0;
      r_row <= '0;
      r_ce  <= 1'b0;
      r_ls  <= 1'b0;
      r_fs  <= 1'b0;
    end else begin
      r_hs  <= w_hs_on ? HS_ON : ~HS_ON;
      r_vs  <= w_vs_on ? VS_ON : ~VS_ON;
      r_de  <= w_act;
      r_vb  <= (w_v >= V_ACTIVE);
      r_col <= w_act ? COL_W'(r_h) : '0;
      r_row <= w_act ? ROW_W'(r_v) : '0;
      r_ce  <= w_tick;
      r_ls  <= w_tick && (r_h == '0);
      r_fs  <= w_tick && (r_h == '0) && (r_v == '0);
    end
  end

  assign vga.hsync       = r_hs;
  assign vga.vsync       = r_vs;
  assign vga.de          = r_de;
  assign vga.vblank      = r_vb;
  assign vga.col         = r_col;
  assign vga.row         = r_row;
  assign vga.pix_ce      = r_ce;
  assign vga.line_start  = r_ls;
  assign vga.frame_start = r_fs;
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: three raster configurations checked every clk against a
// position-from-enabled-clock-count model, plus literal timing pins.
module tb_vga_timing_gen;
  typedef struct packed {
    logic        hs, vs, de, vb;
    logic [15:0] col, row;
    logic        ce, ls, fs;
  } out_t;

  logic clk, rst, en;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  longint n     = 0;
  out_t logA [4096];
  out_t logP [4096];
  out_t logD [4096];
  int   fsq[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  vga_timing_if #(.COL_W(4), .ROW_W(3)) ifA ();
  vga_timing_if #(.COL_W(4), .ROW_W(3)) ifP ();
  vga_timing_if #(.COL_W(10), .ROW_W(9)) ifD ();
  assign ifA.en = en;
  assign ifP.en = en;
  assign ifD.en = en;

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HS_POL(0), .VS_POL(0), .CLK_DIV(1), .COL_W(4), .ROW_W(3)
  ) uA (.i_clk(clk), .i_rst(rst), .vga(ifA.master));

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HS_POL(1), .VS_POL(1), .CLK_DIV(3), .COL_W(4), .ROW_W(3)
  ) uP (.i_clk(clk), .i_rst(rst), .vga(ifP.master));

  vga_timing_gen #(.CLK_DIV(2)) uD (
    .i_clk(clk), .i_rst(rst), .vga(ifD.master)
  );

  // Expected outputs after an edge, given n enabled clks since reset before it.
  function automatic out_t model(
    input int ha, hf, hw, hb, va, vf, vw, vb, hp, vp, dv,
    input longint cnt, input bit e, input bit r
  );
    out_t o;
    longint ht, vt, idx, h, v;
    bit act;
    ht = ha + hf + hw + hb;
    vt = va + vf + vw + vb;
    o = '0;
    o.hs = (hp == 0);
    o.vs = (vp == 0);
    if (r) return o;
    idx = (cnt / dv) % (ht * vt);
    h = idx % ht;
    v = idx / ht;
    act = (h < ha) && (v < va);
    o.de = act;
    o.vb = (v >= va);
    o.col = act ? 16'(h) : 16'd0;
    o.row = act ? 16'(v) : 16'd0;
    if (h >= ha + hf && h < ha + hf + hw) o.hs = (hp != 0);
    if (v >= va + vf && v < va + vf + vw) o.vs = (vp != 0);
    o.ce = e && (cnt % dv == dv - 1);
    o.ls = o.ce && (h == 0);
    o.fs = o.ls && (v == 0);
    return o;
  endfunction

  task automatic cmp(input string nm, input out_t g, input out_t e);
    n_tests++;
    if (g !== e) begin
      n_fail++;
      $display("FAIL model_%s cyc=%0d got=%h exp=%h", nm, cyc, g, e);
    end
  endtask

  task automatic chk(input string nm, input longint act, input longint exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  out_t eA, eP, eD, gA, gP, gD;
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      eA = model(8, 2, 3, 3, 4, 1, 2, 1, 0, 0, 1, n, en, rst);
      eP = model(8, 2, 3, 3, 4, 1, 2, 1, 1, 1, 3, n, en, rst);
      eD = model(640, 16, 96, 48, 480, 10, 2, 33, 0, 0, 2, n, en, rst);
      if (rst) n = 0;
      else if (en) n++;
      @(negedge clk);
      gA = '{ifA.hsync, ifA.vsync, ifA.de, ifA.vblank, 16'(ifA.col),
             16'(ifA.row), ifA.pix_ce, ifA.line_start, ifA.frame_start};
      gP = '{ifP.hsync, ifP.vsync, ifP.de, ifP.vblank, 16'(ifP.col),
             16'(ifP.row), ifP.pix_ce, ifP.line_start, ifP.frame_start};
      gD = '{ifD.hsync, ifD.vsync, ifD.de, ifD.vblank, 16'(ifD.col),
             16'(ifD.row), ifD.pix_ce, ifD.line_start, ifD.frame_start};
      cmp("A", gA, eA);
      cmp("P", gP, eP);
      cmp("D", gD, eD);
      if (cyc < 4096) begin
        logA[cyc] = gA;
        logP[cyc] = gP;
        logD[cyc] = gD;
      end
      if (gA.fs) fsq.push_back(cyc);
    end
  end

  initial begin
    int fa, fp, fd, bad, cnt, first, prev, k, c0, d;
    logic [3:0] colF;
    logic deF, hsF;
    int strobes, chg;
    rst = 1'b1;
    en  = 1'b1;
    step();
    step();
    chk("rstA_hsync", ifA.hsync, 1);
    chk("rstA_vsync", ifA.vsync, 1);
    chk("rstA_de", ifA.de, 0);
    chk("rstP_hsync", ifP.hsync, 0);
    chk("rstP_vsync", ifP.vsync, 0);
    chk("rstD_hsync", ifD.hsync, 1);
    rst = 1'b0;
    repeat (1997) step();

    fa = -1; fp = -1; fd = -1;
    for (int c = 1; c < 30; c++) begin
      if (logA[c].fs && fa < 0) fa = c;
      if (logP[c].fs && fp < 0) fp = c;
      if (logD[c].fs && fd < 0) fd = c;
    end
    chk("A_first_fs_cyc", fa, 3);
    chk("P_first_fs_cyc", fp, 5);
    chk("D_first_fs_cyc", fd, 4);
    chk("A_fs_count", fsq.size(), 16);
    if (fsq.size() >= 3) begin
      chk("A_fs_period0", fsq[1] - fsq[0], 128);
      chk("A_fs_period1", fsq[2] - fsq[1], 128);
    end

    bad = 0; cnt = 0; prev = -1;
    for (int c = 3; c < 2000; c++) begin
      if (logA[c].ls) begin
        if (prev >= 0 && c - prev != 16) bad++;
        prev = c;
        cnt++;
      end
    end
    chk("A_ls_period_bad", bad, 0);
    chk("A_ls_count", cnt, 125);

    bad = 0; cnt = 0;
    for (int c = 3; c < 131; c++) begin
      if (logA[c].de) begin
        if (logA[c].col != 16'(cnt % 8) || logA[c].row != 16'(cnt / 8)) bad++;
        cnt++;
      end
    end
    chk("A_de_count", cnt, 32);
    chk("A_col_row_order_bad", bad, 0);

    cnt = 0; first = -1;
    for (int c = 3; c < 19; c++)
      if (!logA[c].hs) begin cnt++; if (first < 0) first = c; end
    chk("A_hsync_low_clks", cnt, 3);
    chk("A_hsync_first_low", first, 13);

    cnt = 0; first = -1;
    for (int c = 3; c < 131; c++)
      if (!logA[c].vs) begin cnt++; if (first < 0) first = c; end
    chk("A_vsync_low_clks", cnt, 32);
    chk("A_vsync_first_low", first, 83);

    cnt = 0; first = -1;
    for (int c = 3; c < 131; c++)
      if (logA[c].vb) begin cnt++; if (first < 0) first = c; end
    chk("A_vblank_clks", cnt, 64);
    chk("A_vblank_first", first, 67);

    cnt = 0; first = -1;
    for (int c = 3; c < 51; c++)
      if (logP[c].hs) begin cnt++; if (first < 0) first = c; end
    chk("P_hsync_high_clks", cnt, 9);
    chk("P_hsync_first_high", first, 33);

    bad = 0;
    for (int c = 3; c < 2000; c++)
      if (logD[c].ce != (c % 2 == 0)) bad++;
    chk("D_pix_ce_alternate_bad", bad, 0);

    cnt = 0; first = -1;
    for (int c = 3; c < 1603; c++)
      if (!logD[c].hs) begin cnt++; if (first < 0) first = c; end
    chk("D_hsync_low_clks", cnt, 192);
    chk("D_hsync_first_low", first, 1315);

    k = 0;
    while (!(ifA.de && ifA.col == 4'd3) && k < 300) begin step(); k++; end
    chk("wait_A_col3", k < 300, 1);
    en = 1'b0;
    c0 = cyc;
    strobes = 0; chg = 0;
    colF = '0; deF = 1'b0; hsF = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (i == 0) begin colF = ifA.col; deF = ifA.de; hsF = ifA.hsync; end
      strobes += int'(ifA.pix_ce | ifA.line_start | ifA.frame_start);
      if (ifA.col != colF || ifA.de != deF || ifA.hsync != hsF) chg++;
    end
    en = 1'b1;
    chk("gate_strobes", strobes, 0);
    chk("gate_level_changes", chg, 0);
    chk("gate_frozen_col", colF, 4);
    chk("gate_frozen_de", deF, 1);
    k = 0;
    while (ifA.col == colF && k < 10) begin step(); k++; end
    chk("resume_col", ifA.col, colF + 1);
    k = 0;
    while (fsq[$] <= c0 && k < 300) begin step(); k++; end
    d = -1;
    for (int i = 1; i < fsq.size(); i++)
      if (fsq[i-1] < c0 && fsq[i] > c0) d = fsq[i] - fsq[i-1];
    chk("gate_frame_stretch", d, 133);

    k = 0;
    while (n % 128 != 41 && k < 300) begin step(); k++; end
    chk("wait_h9_v2", k < 300, 1);
    rst = 1'b1;
    step();
    chk("midrst_A_outputs",
        {ifA.hsync, ifA.vsync, ifA.de, ifA.vblank, ifA.pix_ce,
         ifA.line_start, ifA.frame_start, ifA.col, ifA.row},
        14'b11_00000_0000_000);
    chk("midrst_P_syncs", {ifP.hsync, ifP.vsync}, 0);
    chk("midrst_D_de", ifD.de, 0);
    rst = 1'b0;
    step();
    chk("post_rst_A_fs", ifA.frame_start, 1);
    chk("post_rst_A_colrow", {ifA.col, ifA.row}, 0);
    chk("post_rst_A_de", ifA.de, 1);
    chk("post_rst_D_fs_edge1", ifD.frame_start, 0);
    step();
    chk("post_rst_D_fs_edge2", ifD.frame_start, 1);
    chk("post_rst_D_colrow", {ifD.col, ifD.row}, 0);
    repeat (60) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
